// File: rtl/usbf_ep_tx_stream_pkg.sv
// Shared USB PID constants and helpers for the IN-endpoint transmit path.
package usbf_ep_tx_stream_pkg;

  typedef logic [7:0] pid_t;

  localparam pid_t PID_DATA0 = 8'hC3;
  localparam pid_t PID_DATA1 = 8'h4B;
  localparam pid_t PID_NAK   = 8'h5A;
  localparam pid_t PID_STALL = 8'h1E;

  function automatic pid_t data_pid(input logic toggle);
    return toggle ? PID_DATA1 : PID_DATA0;
  endfunction

endpackage

// File: rtl/usbf_ep_tx_stream_if.sv
// PID request plus data stream between the endpoint buffer (master) and the SIE transmitter (slave).
interface usbf_ep_tx_stream_if;
  import usbf_ep_tx_stream_pkg::*;

  logic       tx_valid;
  pid_t       tx_pid;
  logic       tx_accept;
  logic       data_valid;
  logic       data_strb;
  logic [7:0] data;
  logic       data_last;
  logic       data_accept;

  modport master (
    output tx_valid, tx_pid, data_valid, data_strb, data, data_last,
    input  tx_accept, data_accept
  );

  modport slave (
    input  tx_valid, tx_pid, data_valid, data_strb, data, data_last,
    output tx_accept, data_accept
  );

endinterface

// File: rtl/usbf_ep_tx_ram.sv
// DEPTH x 8 packet store: synchronous write, asynchronous read.
module usbf_ep_tx_ram #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [7:0]        wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [7:0]        rdata_o
);

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/usbf_ep_tx_stream.sv
// Single-packet IN-endpoint buffer: answers IN tokens with DATA0/1 + payload, NAK or STALL,
// and keeps the packet until the host ACKs it so retries resend identical bytes.
module usbf_ep_tx_stream
  import usbf_ep_tx_stream_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 enable_i,
  input  logic                 wr_valid_i,
  input  logic [7:0]           wr_data_i,
  output logic                 wr_ready_o,
  input  logic                 commit_i,
  input  logic                 flush_i,
  input  logic                 stall_i,
  input  logic                 send_i,
  input  logic                 ack_i,
  input  logic                 retry_i,
  input  logic                 toggle_set_i,
  input  logic                 toggle_clr_i,
  usbf_ep_tx_stream_if.master  sie,
  output logic                 busy_o,
  output logic [ADDR_W:0]      level_o,
  output logic                 sent_o,
  output logic                 toggle_o
);

  typedef enum logic [2:0] {ST_IDLE, ST_HS, ST_REQ, ST_DATA, ST_HOLD} state_e;

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W+1)'(1);

  state_e          state_q, state_d;
  logic [ADDR_W:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic            committed_q, committed_d;
  logic            toggle_q, toggle_d;
  logic            sent_q, sent_d;
  pid_t            pid_q, pid_d;

  logic            wr_fire, stream_vld, zlp, last;
  logic [7:0]      ram_rdata;

  assign wr_ready_o = !committed_q && (wr_ptr_q < DEPTH_L);
  assign wr_fire    = enable_i && !flush_i && wr_valid_i && wr_ready_o;
  assign stream_vld = (state_q == ST_REQ) || (state_q == ST_DATA);
  assign zlp        = (wr_ptr_q == '0);
  assign last       = zlp || (rd_ptr_q == wr_ptr_q - PTR_ONE);

  usbf_ep_tx_ram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
    .clk_i   (clk_i),
    .we_i    (wr_fire),
    .waddr_i (wr_ptr_q[ADDR_W-1:0]),
    .wdata_i (wr_data_i),
    .raddr_i (rd_ptr_q[ADDR_W-1:0]),
    .rdata_o (ram_rdata)
  );

  // Stream is presented already in REQ so the SIE can spot a ZLP at PID accept.
  assign sie.tx_valid   = (state_q == ST_HS) || (state_q == ST_REQ);
  assign sie.tx_pid     = sie.tx_valid ? pid_q : '0;
  assign sie.data_valid = stream_vld;
  assign sie.data_strb  = stream_vld && !zlp;
  assign sie.data       = (stream_vld && !zlp) ? ram_rdata : '0;
  assign sie.data_last  = stream_vld && last;

  assign busy_o   = (state_q != ST_IDLE);
  assign level_o  = wr_ptr_q;
  assign sent_o   = sent_q;
  assign toggle_o = toggle_q;

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    committed_d = committed_q;
    toggle_d    = toggle_q;
    pid_d       = pid_q;
    sent_d      = 1'b0;

    if (wr_fire)  wr_ptr_d    = wr_ptr_q + PTR_ONE;
    if (commit_i) committed_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (send_i) begin
          if (stall_i) begin
            pid_d   = PID_STALL;
            state_d = ST_HS;
          end else if (!committed_q) begin
            pid_d   = PID_NAK;
            state_d = ST_HS;
          end else begin
            pid_d    = data_pid(toggle_q);
            rd_ptr_d = '0;
            state_d  = ST_REQ;
          end
        end
      end
      ST_HS: begin
        if (sie.tx_accept) state_d = ST_IDLE;
      end
      ST_REQ, ST_DATA: begin
        if (state_q == ST_REQ && sie.tx_accept) state_d = ST_DATA;
        if (sie.data_accept) begin
          rd_ptr_d = rd_ptr_q + PTR_ONE;
          if (last) state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (ack_i) begin
          wr_ptr_d    = '0;
          rd_ptr_d    = '0;
          committed_d = 1'b0;
          toggle_d    = !toggle_q;
          sent_d      = 1'b1;
          state_d     = ST_IDLE;
        end else if (retry_i) begin
          rd_ptr_d = '0;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (toggle_clr_i) toggle_d = 1'b0;
    if (toggle_set_i) toggle_d = 1'b1;

    if (flush_i) begin
      state_d     = ST_IDLE;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      committed_d = 1'b0;
      sent_d      = 1'b0;
    end

    if (!enable_i) begin
      state_d     = ST_IDLE;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      committed_d = 1'b0;
      toggle_d    = 1'b0;
      sent_d      = 1'b0;
      pid_d       = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      committed_q <= 1'b0;
      toggle_q    <= 1'b0;
      sent_q      <= 1'b0;
      pid_q       <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      committed_q <= committed_d;
      toggle_q    <= toggle_d;
      sent_q      <= sent_d;
      pid_q       <= pid_d;
    end
  end

endmodule
